rr_arbiter4: RTL and testbench
==============================

# rr_arbiter4

Four-requester arbiter that shares a single downstream resource, such as a bus port or a shared encoder/datapath slot. It chooses a winner each arbitration cycle using either fixed priority (highest index wins, the same ordering as the team's 4-to-2 priority encoder) or rotating round-robin priority. The winner holds the grant until it drops its request, or until a hold limit is reached while others are waiting. It sits between request-generating clients and the shared resource, and drives the one-hot grant, the binary grant index and a valid flag.

## Interface
- MAX_HOLD, default 8: maximum consecutive granted cycles when another requester is waiting; legal range 2..255.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req  in  4  request vector; bit i is held high by client i while it wants the resource
- rr_en  in  1  1 = round-robin priority, 0 = fixed priority (index 3 highest); sampled only in arbitration cycles
- gnt  out  4  one-hot grant, registered
- gnt_bin  out  2  binary index of the granted client, registered; 0 when gnt_vld=0
- gnt_vld  out  1  1 when any gnt bit is set
- preempt  out  1  one-cycle pulse in the cycle the grant is removed because of the hold limit

## Operation
- State machine with three states:
  - IDLE: no grant; arbitration happens every cycle.
  - BUSY: grant held.
  - GAP: one dead cycle after a release; arbitration also happens in this cycle.
- Arbitration, evaluated in IDLE and GAP only:
  - Fixed mode (rr_en=0): the winner is the highest set index of req.
  - Round-robin mode (rr_en=1): search req starting at pointer ptr, ascending and wrapping 3→0; the first set bit wins.
  - If no req bit is set, stay in or go to IDLE with no grant.
- Granting:
  - Winner w: next cycle gnt=1<<w, gnt_bin=w, gnt_vld=1, state BUSY, hold_cnt=1.
  - ptr ← (w+1) mod 4, updated in both modes.
- BUSY, per cycle:
  - If req[owner]=0: release. Next cycle gnt=0, state GAP, preempt=0.
  - Else if hold_cnt==MAX_HOLD and any other req bit is set: forced release. Next cycle gnt=0, preempt=1, state GAP.
  - Else: hold. hold_cnt increments, saturating at MAX_HOLD.
- Uncontended owner: holds indefinitely. The counter saturates, and preemption happens as soon as another request appears while hold_cnt==MAX_HOLD.
- A preempted owner keeps req high and competes normally. Because ptr has already advanced past it, in round-robin mode it loses to any other waiting requester.
- GAP always lasts exactly one cycle. No client is ever granted in two consecutive grant periods without a gnt=0 cycle in between.
- Requests from non-owners during BUSY are ignored until the next arbitration.
- Widths:
  - hold_cnt is $clog2(MAX_HOLD+1) bits.
  - ptr is 2 bits with natural wrap.
- Reset (rst_n=0, asynchronous): gnt=0, gnt_bin=0, gnt_vld=0, preempt=0, ptr=0, hold_cnt=0, state IDLE. Asserting reset mid-grant drops gnt immediately; no GAP cycle follows reset.

## Timing
- Request to grant latency: 1 cycle. A req rising at edge k produces gnt at edge k+1 from IDLE.
- Release latency: req[owner] observed low at edge k → gnt=0 after edge k. The earliest new grant is after edge k+1, so the resource is idle for at least one cycle.
- Forced release: grant duration is exactly MAX_HOLD cycles when another requester is waiting throughout. preempt is high only in the first gnt=0 cycle.
- All outputs are registered; there are no combinational paths from req or rr_en to any output.
- gnt_vld equals |gnt in every cycle. gnt is always zero-hot or one-hot.

## Test plan
- Reset and idle:
  - Stimulus: assert rst_n=0 mid-grant.
  - Required: gnt, gnt_bin, gnt_vld and preempt go to 0 immediately. After release with req=0, outputs stay 0.
  - Stimulus: req=4'b0100, rr_en=0.
  - Required: gnt=4'b0100 and gnt_bin=2 one cycle later.
- Fixed priority:
  - Stimulus: req=4'b1011, rr_en=0, each owner dropping req after 3 granted cycles.
  - Required: grant order 3, 1, 0 with one gnt=0 cycle between each grant.
- Round-robin rotation:
  - Stimulus: rr_en=1, req=4'b1111 held constant, MAX_HOLD=8.
  - Required: grants 0, 1, 2, 3, 0…, each exactly 8 cycles long, with preempt pulsing once per handover.
- Uncontended hold:
  - Stimulus: only req[2] high for 20 cycles; then req[0] rises at cycle 20.
  - Required: gnt=4'b0100 for the whole 20 cycles with no preempt. gnt drops one cycle later with preempt=1, and gnt=4'b0001 follows after the GAP cycle.
- Release and GAP:
  - Stimulus: owner 1 drops req after 2 cycles while req[3] is high, rr_en=1.
  - Required: sequence gnt=0010, 0010, 0000 (preempt=0), then 1000.
- Mode switch:
  - Stimulus: toggle rr_en while BUSY.
  - Required: the current grant is unaffected; the new mode applies at the next arbitration.

Source files
------------

// File: rtl/rr_arbiter4_if.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter4_if
// Brief    : Request/grant bundle between four clients and rr_arbiter4.
//            master = client side, slave = arbiter side.
// Revision : 1.0  initial release
// ============================================================================
interface rr_arbiter4_if;
    logic [3:0] req;
    logic       rr_en;
    logic [3:0] gnt;
    logic [1:0] gnt_bin;
    logic       gnt_vld;
    logic       preempt;

    modport master (
        output req,
        output rr_en,
        input  gnt,
        input  gnt_bin,
        input  gnt_vld,
        input  preempt
    );

    modport slave (
        input  req,
        input  rr_en,
        output gnt,
        output gnt_bin,
        output gnt_vld,
        output preempt
    );
endinterface
`default_nettype wire

// File: rtl/rr_arbiter4.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter4
// Brief    : Four-requester arbiter, fixed (index 3 highest) or round-robin
//            priority, with a hold limit and a one-cycle dead gap after every
//            release. All outputs are registered.
// Revision : 1.0  initial release
// ============================================================================
module rr_arbiter4 #(
    parameter int MAX_HOLD = 8
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    rr_arbiter4_if.slave     bus
);

    localparam int                  c_cnt_w    = $clog2(MAX_HOLD + 1);
    localparam logic [c_cnt_w-1:0]  c_max_hold = c_cnt_w'(MAX_HOLD);
    localparam logic [c_cnt_w-1:0]  c_cnt_one  = c_cnt_w'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t               r_state;
    logic [3:0]           r_gnt;
    logic [1:0]           r_gnt_bin;
    logic                 r_gnt_vld;
    logic                 r_preempt;
    logic [1:0]           r_ptr;
    logic [c_cnt_w-1:0]   r_hold_cnt;

    state_t               w_state_nxt;
    logic [3:0]           w_gnt_nxt;
    logic [1:0]           w_gnt_bin_nxt;
    logic                 w_gnt_vld_nxt;
    logic                 w_preempt_nxt;
    logic [1:0]           w_ptr_nxt;
    logic [c_cnt_w-1:0]   w_hold_cnt_nxt;

    logic                 w_req_any;
    logic [1:0]           w_fix_win;
    logic [7:0]           w_req_dbl;
    logic [3:0]           w_req_rot;
    logic [1:0]           w_rr_off;
    logic [1:0]           w_win;
    logic                 w_owner_req;
    logic                 w_others;

    // Winner selection: highest index in fixed mode; in round-robin mode the
    // request vector is rotated so that ptr lands at bit 0, then the lowest
    // set bit is taken and un-rotated by adding ptr back.
    always_comb begin
        w_req_any = |bus.req;

        casez (bus.req)
            4'b1???: w_fix_win = 2'd3;
            4'b01??: w_fix_win = 2'd2;
            4'b001?: w_fix_win = 2'd1;
            default: w_fix_win = 2'd0;
        endcase

        w_req_dbl = {bus.req, bus.req};
        w_req_rot = w_req_dbl[{1'b0, r_ptr} +: 4];

        casez (w_req_rot)
            4'b???1: w_rr_off = 2'd0;
            4'b??10: w_rr_off = 2'd1;
            4'b?100: w_rr_off = 2'd2;
            default: w_rr_off = 2'd3;
        endcase

        w_win       = bus.rr_en ? (r_ptr + w_rr_off) : w_fix_win;
        w_owner_req = bus.req[r_gnt_bin];
        w_others    = |(bus.req & ~r_gnt);
    end

    // Next-state and next-output logic: arbitrate in IDLE/GAP, hold or
    // release in BUSY. Any release always passes through one GAP cycle.
    always_comb begin
        w_state_nxt    = r_state;
        w_gnt_nxt      = r_gnt;
        w_gnt_bin_nxt  = r_gnt_bin;
        w_gnt_vld_nxt  = r_gnt_vld;
        w_preempt_nxt  = 1'b0;
        w_ptr_nxt      = r_ptr;
        w_hold_cnt_nxt = r_hold_cnt;

        case (r_state)
            ST_IDLE, ST_GAP: begin
                if (w_req_any) begin
                    w_state_nxt    = ST_BUSY;
                    w_gnt_nxt      = 4'd1 << w_win;
                    w_gnt_bin_nxt  = w_win;
                    w_gnt_vld_nxt  = 1'b1;
                    w_hold_cnt_nxt = c_cnt_one;
                    w_ptr_nxt      = w_win + 2'd1;
                end else begin
                    w_state_nxt    = ST_IDLE;
                    w_gnt_nxt      = 4'd0;
                    w_gnt_bin_nxt  = 2'd0;
                    w_gnt_vld_nxt  = 1'b0;
                    w_hold_cnt_nxt = '0;
                end
            end
            ST_BUSY: begin
                if (!w_owner_req || ((r_hold_cnt == c_max_hold) && w_others)) begin
                    // Voluntary drop takes priority; otherwise the hold
                    // limit with someone waiting forces the owner off.
                    w_state_nxt    = ST_GAP;
                    w_gnt_nxt      = 4'd0;
                    w_gnt_bin_nxt  = 2'd0;
                    w_gnt_vld_nxt  = 1'b0;
                    w_hold_cnt_nxt = '0;
                    w_preempt_nxt  = w_owner_req;
                end else if (r_hold_cnt != c_max_hold) begin
                    w_hold_cnt_nxt = r_hold_cnt + c_cnt_one;
                end
            end
            default: begin
                w_state_nxt    = ST_IDLE;
                w_gnt_nxt      = 4'd0;
                w_gnt_bin_nxt  = 2'd0;
                w_gnt_vld_nxt  = 1'b0;
                w_hold_cnt_nxt = '0;
            end
        endcase
    end

    // State and output registers; reset drops any grant immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_gnt      <= 4'd0;
            r_gnt_bin  <= 2'd0;
            r_gnt_vld  <= 1'b0;
            r_preempt  <= 1'b0;
            r_ptr      <= 2'd0;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_gnt      <= w_gnt_nxt;
            r_gnt_bin  <= w_gnt_bin_nxt;
            r_gnt_vld  <= w_gnt_vld_nxt;
            r_preempt  <= w_preempt_nxt;
            r_ptr      <= w_ptr_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
        end
    end

    assign bus.gnt     = r_gnt;
    assign bus.gnt_bin = r_gnt_bin;
    assign bus.gnt_vld = r_gnt_vld;
    assign bus.preempt = r_preempt;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter4.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_arbiter4
// Brief    : Self-checking bench for rr_arbiter4: directed scenarios with
//            literal expectations plus randomized traffic against a
//            behavioural owner/pointer model.
// Revision : 1.0  initial release
// ============================================================================
module tb_rr_arbiter4;

    localparam int MH = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    rr_arbiter4_if bus ();

    rr_arbiter4 #(.MAX_HOLD(MH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model: who owns the resource (-1 = nobody), how long,
    // and where the round-robin search starts.
    int         m_owner = -1;
    int         m_cnt   = 0;
    int         m_ptr   = 0;
    int         m_w;
    logic [3:0] m_req;
    logic [3:0] e_gnt = 4'd0;
    logic [1:0] e_bin = 2'd0;
    logic       e_vld = 1'b0;
    logic       e_pre = 1'b0;

    // Advance the model one clock using the requests seen at the edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner = -1; m_cnt = 0; m_ptr = 0;
            e_gnt = 4'd0; e_bin = 2'd0; e_vld = 1'b0; e_pre = 1'b0;
        end else begin
            m_req = bus.req;
            e_pre = 1'b0;
            if (m_owner < 0) begin
                if (m_req != 4'd0) begin
                    m_w = -1;
                    if (bus.rr_en) begin
                        for (int k = 0; k < 4; k++)
                            if (m_w < 0 && m_req[(m_ptr + k) % 4]) m_w = (m_ptr + k) % 4;
                    end else begin
                        for (int c = 3; c >= 0; c--)
                            if (m_w < 0 && m_req[c]) m_w = c;
                    end
                    m_owner = m_w;
                    m_cnt   = 1;
                    m_ptr   = (m_w + 1) % 4;
                end
            end else if (!m_req[m_owner]) begin
                m_owner = -1;
            end else if (m_cnt == MH && (m_req & ~(4'b0001 << m_owner)) != 4'd0) begin
                m_owner = -1;
                e_pre   = 1'b1;
            end else if (m_cnt < MH) begin
                m_cnt++;
            end
            e_vld = (m_owner >= 0);
            e_gnt = e_vld ? (4'b0001 << m_owner) : 4'd0;
            e_bin = e_vld ? m_owner[1:0] : 2'd0;
        end
    end

    // Compare DUT against the model every cycle, mid-period.
    always @(negedge clk) begin
        vectors++;
        if (bus.gnt !== e_gnt || bus.gnt_bin !== e_bin ||
            bus.gnt_vld !== e_vld || bus.preempt !== e_pre) begin
            miscompares++;
            $display("FAIL model t=%0t got gnt=%b bin=%0d vld=%b pre=%b want gnt=%b bin=%0d vld=%b pre=%b",
                     $time, bus.gnt, bus.gnt_bin, bus.gnt_vld, bus.preempt,
                     e_gnt, e_bin, e_vld, e_pre);
        end
        vectors++;
        if ($countones(bus.gnt) > 1 || bus.gnt_vld !== (|bus.gnt)) begin
            miscompares++;
            $display("FAIL onehot t=%0t got gnt=%b vld=%b", $time, bus.gnt, bus.gnt_vld);
        end
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0t got %0h want %0h", nm, $time, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    int len;

    initial begin
        bus.req   = 4'd0;
        bus.rr_en = 1'b0;

        // Reset and idle
        repeat (3) step();
        rst_n = 1'b1;
        step(); step();
        chk("idle_gnt", 8'(bus.gnt), 8'h0);
        chk("idle_vld", 8'(bus.gnt_vld), 8'h0);

        bus.req = 4'b0100;
        step();
        chk("first_gnt", 8'(bus.gnt), 8'h4);
        chk("first_bin", 8'(bus.gnt_bin), 8'h2);
        chk("first_vld", 8'(bus.gnt_vld), 8'h1);
        step(); step();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_gnt", 8'(bus.gnt), 8'h0);
        chk("rst_bin", 8'(bus.gnt_bin), 8'h0);
        chk("rst_vld", 8'(bus.gnt_vld), 8'h0);
        chk("rst_pre", 8'(bus.preempt), 8'h0);
        bus.req = 4'd0;
        step();
        rst_n = 1'b1;
        step(); step();
        chk("post_rst_gnt", 8'(bus.gnt), 8'h0);

        // Fixed priority: 3, then 1, then 0
        bus.req = 4'b1011; bus.rr_en = 1'b0;
        step();
        chk("fp_g3", 8'(bus.gnt), 8'h8);
        step(); step();
        bus.req = 4'b0011;
        step();
        chk("fp_gap1", 8'(bus.gnt), 8'h0);
        chk("fp_gap1_pre", 8'(bus.preempt), 8'h0);
        step();
        chk("fp_g1", 8'(bus.gnt), 8'h2);
        step(); step();
        bus.req = 4'b0001;
        step();
        chk("fp_gap2", 8'(bus.gnt), 8'h0);
        step();
        chk("fp_g0", 8'(bus.gnt), 8'h1);
        step(); step();
        bus.req = 4'd0;
        step(); step();
        chk("fp_idle", 8'(bus.gnt), 8'h0);

        // Round-robin rotation from a fresh pointer
        #2 rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        chk("model_ptr_rr", 8'(m_ptr), 8'h0);
        bus.rr_en = 1'b1; bus.req = 4'b1111;
        step();
        for (int g = 0; g < 5; g++) begin
            len = 0;
            while (bus.gnt == (4'b0001 << (g % 4)) && len < 20) begin
                len++;
                step();
            end
            chk($sformatf("rr_len%0d", g), 8'(len), 8'(MH));
            chk($sformatf("rr_gap%0d", g), {6'd0, bus.gnt_vld, bus.preempt}, 8'h1);
            step();
        end
        bus.req = 4'd0;
        step(); step();

        // Uncontended hold, then preempted by req[0]
        bus.req = 4'b0100;
        step();
        for (int i = 0; i < 20; i++) begin
            chk("unc_gnt", 8'(bus.gnt), 8'h4);
            chk("unc_pre", 8'(bus.preempt), 8'h0);
            if (i < 19) step();
        end
        bus.req = 4'b0101;
        step();
        chk("unc_drop", 8'(bus.gnt), 8'h0);
        chk("unc_drop_pre", 8'(bus.preempt), 8'h1);
        step();
        chk("unc_next", 8'(bus.gnt), 8'h1);
        chk("unc_next_pre", 8'(bus.preempt), 8'h0);
        bus.req = 4'd0;
        step(); step();

        // Release and GAP
        bus.req = 4'b1010;
        step();
        chk("rel_g1a", 8'(bus.gnt), 8'h2);
        step();
        chk("rel_g1b", 8'(bus.gnt), 8'h2);
        bus.req = 4'b1000;
        step();
        chk("rel_gap", 8'(bus.gnt), 8'h0);
        chk("rel_gap_pre", 8'(bus.preempt), 8'h0);
        step();
        chk("rel_g3", 8'(bus.gnt), 8'h8);
        chk("model_ptr_rel", 8'(m_ptr), 8'h0);

        // Mode switch while busy: grant unaffected, fixed mode at next arbitration
        bus.req = 4'b1011;
        step();
        chk("ms_hold1", 8'(bus.gnt), 8'h8);
        bus.rr_en = 1'b0;
        step();
        chk("ms_hold2", 8'(bus.gnt), 8'h8);
        bus.rr_en = 1'b1;
        step();
        chk("ms_hold3", 8'(bus.gnt), 8'h8);
        bus.rr_en = 1'b0; bus.req = 4'b0011;
        step();
        chk("ms_gap", 8'(bus.gnt), 8'h0);
        step();
        chk("ms_fixed", 8'(bus.gnt), 8'h2);
        bus.req = 4'd0;
        step(); step();

        // Randomized traffic checked by the model every cycle
        for (int n = 0; n < 3000; n++) begin
            step();
            for (int i = 0; i < 4; i++)
                if ($urandom_range(7) == 0) bus.req[i] = ~bus.req[i];
            if ($urandom_range(15) == 0) bus.rr_en = ~bus.rr_en;
            if ($urandom_range(599) == 0) begin
                #2 rst_n = 1'b0;
                step();
                rst_n = 1'b1;
            end
        end
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
